ibex_mem_responder: RTL and testbench

IBEX_MEM_RESPONDER -- requirements
Module: ibex_mem_responder

---
 rtl/ibex_pkg.sv | 29 ++
 rtl/ibex_mem_resp_pipe.sv | 42 ++++
 rtl/ibex_mem_responder.sv | 92 +++++++++
 tb/tb_ibex_mem_responder.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/ibex_pkg.sv
// Shared types and constants for the memory responder and its response pipeline.
package ibex_pkg;

    localparam int MEM_RESP_MAX_LATENCY = 4;
    // Wide enough to hold an outstanding count of up to 4.
    localparam int CNT_W = 3;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } mem_resp_t;

    typedef struct packed {
        logic      valid;
        mem_resp_t resp;
    } pipe_entry_t;

    function automatic logic [31:0] apply_be(input logic [31:0] old_word,
                                             input logic [31:0] wdata,
                                             input logic [3:0]  be);
        logic [31:0] merged;
        merged = old_word;
        for (int k = 0; k < 4; k++) begin
            if (be[k]) merged[8*k +: 8] = wdata[8*k +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/ibex_mem_resp_pipe.sv
// Fixed-latency response delay line: one entry enters per cycle and leaves
// exactly Latency cycles later. Empty entries carry all-zero payload.
module ibex_mem_resp_pipe
    import ibex_pkg::*;
#(
    parameter int Latency = 1
) (
    input  logic      clk_i,
    input  logic      rst_i,
    input  logic      clear_i,
    input  logic      in_valid,
    input  mem_resp_t in_resp,
    output logic      out_valid,
    output mem_resp_t out_resp
);

    pipe_entry_t stage_q [Latency];
    pipe_entry_t stage_d;

    always_comb begin
        stage_d = '0;
        if (in_valid) begin
            stage_d.valid = 1'b1;
            stage_d.resp  = in_resp;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < Latency; i++) stage_q[i] <= '0;
        end else if (clear_i) begin
            for (int i = 0; i < Latency; i++) stage_q[i] <= '0;
        end else begin
            stage_q[0] <= stage_d;
            for (int i = 1; i < Latency; i++) stage_q[i] <= stage_q[i-1];
        end
    end

    assign out_valid = stage_q[Latency-1].valid;
    assign out_resp  = stage_q[Latency-1].resp;

endmodule

// File: rtl/ibex_mem_responder.sv
// Memory model answering Ibex-style req/gnt/rvalid transactions with a fixed
// response latency, a bounded number of in-flight requests and an error window.
module ibex_mem_responder
    import ibex_pkg::*;
#(
    parameter int          Depth          = 1024,
    parameter int          Latency        = 1,
    parameter int          MaxOutstanding = 2,
    parameter logic [31:0] ErrAddr        = 32'hFFFF_F000,
    parameter logic [31:0] ErrMask        = 32'hFFFF_F000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        setback_i,
    input  logic        stall_i,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [3:0]  be_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        gnt_o,
    output logic        rvalid_o,
    output logic [31:0] rdata_o,
    output logic        err_o
);

    localparam int AW = $clog2(Depth);

    // Handshake: a request is accepted in a cycle where req_i and gnt_o are both
    // high; its single response shows up as a one-cycle rvalid_o pulse, in order.
    logic [31:0]      mem [Depth];
    logic [AW-1:0]    idx;
    logic             in_range;
    logic             in_err_window;
    logic             req_err;
    logic             accept;
    logic [CNT_W-1:0] count_q;
    mem_resp_t        resp_d;
    mem_resp_t        resp_q;
    logic             unused_addr_bits;

    assign idx              = addr_i[AW+1:2];
    assign in_range         = (addr_i[31:AW+2] == '0);
    assign in_err_window    = ((addr_i & ErrMask) == ErrAddr);
    assign req_err          = !in_range || in_err_window;
    assign unused_addr_bits = ^addr_i[1:0];

    // No credit bypass: a response retiring this cycle frees its slot next cycle.
    assign gnt_o  = req_i && !stall_i && !setback_i && !rst_i
                    && (count_q < CNT_W'(MaxOutstanding));
    assign accept = gnt_o;

    always_comb begin
        resp_d     = '0;
        resp_d.err = req_err;
        if (!we_i && !req_err) resp_d.rdata = mem[idx];
    end

    always_ff @(posedge clk_i) begin
        if (accept && we_i && !req_err) mem[idx] <= apply_be(mem[idx], wdata_i, be_i);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else if (setback_i) begin
            count_q <= '0;
        end else begin
            case ({accept, rvalid_o})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    ibex_mem_resp_pipe #(
        .Latency (Latency)
    ) u_pipe (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .clear_i   (setback_i),
        .in_valid  (accept),
        .in_resp   (resp_d),
        .out_valid (rvalid_o),
        .out_resp  (resp_q)
    );

    assign rdata_o = resp_q.rdata;
    assign err_o   = resp_q.err;

endmodule

// File: tb/tb_ibex_mem_responder.sv
// Directed bench for ibex_mem_responder: a default instance (Latency 1) and a
// Latency 3 / MaxOutstanding 3 instance share one clock.
module tb_ibex_mem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q [$];

    // Instance a: defaults.
    logic        a_rst = 1'b1, a_setback = 1'b0, a_stall = 1'b0;
    logic        a_req = 1'b0, a_we = 1'b0;
    logic [3:0]  a_be = 4'h0;
    logic [31:0] a_addr = '0, a_wdata = '0;
    logic        a_gnt, a_rvalid, a_err;
    logic [31:0] a_rdata;

    // Instance b: Latency 3, MaxOutstanding 3.
    logic        b_rst = 1'b1, b_setback = 1'b0, b_stall = 1'b0;
    logic        b_req = 1'b0, b_we = 1'b0;
    logic [3:0]  b_be = 4'h0;
    logic [31:0] b_addr = '0, b_wdata = '0;
    logic        b_gnt, b_rvalid, b_err;
    logic [31:0] b_rdata;

    ibex_mem_responder u_a (
        .clk_i(clk), .rst_i(a_rst), .setback_i(a_setback), .stall_i(a_stall),
        .req_i(a_req), .we_i(a_we), .be_i(a_be), .addr_i(a_addr), .wdata_i(a_wdata),
        .gnt_o(a_gnt), .rvalid_o(a_rvalid), .rdata_o(a_rdata), .err_o(a_err)
    );

    ibex_mem_responder #(.Latency(3), .MaxOutstanding(3)) u_b (
        .clk_i(clk), .rst_i(b_rst), .setback_i(b_setback), .stall_i(b_stall),
        .req_i(b_req), .we_i(b_we), .be_i(b_be), .addr_i(b_addr), .wdata_i(b_wdata),
        .gnt_o(b_gnt), .rvalid_o(b_rvalid), .rdata_o(b_rdata), .err_o(b_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the response cycle.
    task automatic a_single(input string tag, input logic we, input logic [3:0] be,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [31:0] exp_rdata, input logic exp_err);
        a_req = 1'b1; a_we = we; a_be = be; a_addr = addr; a_wdata = wdata;
        @(negedge clk);
        chk1({tag, "_gnt"}, a_gnt, 1'b1);
        chk1({tag, "_rv_early"}, a_rvalid, 1'b0);
        @(posedge clk); #1;
        a_req = 1'b0;
        @(negedge clk);
        chk1({tag, "_rvalid"}, a_rvalid, 1'b1);
        chk({tag, "_rdata"}, a_rdata, exp_rdata);
        chk1({tag, "_err"}, a_err, exp_err);
        @(posedge clk); #1;
    endtask

    logic [7:0]  exp_gnt;
    logic [7:0]  exp_rv;
    logic [31:0] rd_addr [3];

    initial begin
        exp_gnt = 8'b0111_0111;
        exp_rv  = 8'b1011_1000;
        rd_addr[0] = 32'h10; rd_addr[1] = 32'h20; rd_addr[2] = 32'h0;

        // Reset state, with a request pending.
        a_req = 1'b1; b_req = 1'b1;
        #3;
        chk1("rst_a_gnt", a_gnt, 1'b0);
        chk1("rst_a_rvalid", a_rvalid, 1'b0);
        chk("rst_a_rdata", a_rdata, 32'h0);
        chk1("rst_a_err", a_err, 1'b0);
        chk1("rst_b_gnt", b_gnt, 1'b0);
        @(posedge clk); #1;
        a_rst = 1'b0; b_rst = 1'b0; a_req = 1'b0; b_req = 1'b0;

        // Write then read, byte enables, error window.
        a_single("wr10", 1'b1, 4'hF, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0);
        a_single("rd10", 1'b0, 4'h0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);
        @(negedge clk);
        chk1("idle_rvalid", a_rvalid, 1'b0);
        chk("idle_rdata", a_rdata, 32'h0);
        @(posedge clk); #1;
        a_single("wr20", 1'b1, 4'hF, 32'h20, 32'h11223344, 32'h0, 1'b0);
        a_single("wr20_be", 1'b1, 4'b0101, 32'h20, 32'hAABBCCDD, 32'h0, 1'b0);
        a_single("rd20", 1'b0, 4'hF, 32'h20, 32'h0, 32'h11BB33DD, 1'b0);
        a_single("wr0", 1'b1, 4'hF, 32'h0, 32'hCAFEF00D, 32'h0, 1'b0);
        a_single("rd_errwin", 1'b0, 4'hF, 32'hFFFF_F004, 32'h0, 32'h0, 1'b1);
        a_single("wr_oob", 1'b1, 4'hF, 32'h1000, 32'h12345678, 32'h0, 1'b1);
        a_single("rd0", 1'b0, 4'hF, 32'h0, 32'h0, 32'hCAFEF00D, 1'b0);

        // Stall withholds grant.
        a_req = 1'b1; a_stall = 1'b1; a_we = 1'b0; a_addr = 32'h10;
        @(negedge clk);
        chk1("stall_gnt", a_gnt, 1'b0);
        @(posedge clk); #1;
        a_req = 1'b0; a_stall = 1'b0;

        // Back-to-back reads, in-order responses.
        exp_q.push_back(32'hDEADBEEF);
        exp_q.push_back(32'h11BB33DD);
        exp_q.push_back(32'hCAFEF00D);
        for (int i = 0; i < 4; i++) begin
            if (i < 3) begin
                a_req = 1'b1; a_we = 1'b0; a_addr = rd_addr[i];
            end else begin
                a_req = 1'b0;
            end
            @(negedge clk);
            if (i < 3) chk1($sformatf("b2b_gnt%0d", i), a_gnt, 1'b1);
            if (i > 0) begin
                chk1($sformatf("b2b_rv%0d", i), a_rvalid, 1'b1);
                chk($sformatf("b2b_rdata%0d", i), a_rdata, exp_q.pop_front());
            end
            @(posedge clk); #1;
        end

        // Credit limit on instance b.
        b_req = 1'b1; b_we = 1'b1; b_be = 4'hF; b_addr = 32'h40; b_wdata = 32'h600DCAFE;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            chk1($sformatf("cred_gnt_c%0d", c), b_gnt, exp_gnt[c]);
            chk1($sformatf("cred_rv_c%0d", c), b_rvalid, exp_rv[c]);
            @(posedge clk); #1;
        end
        b_req = 1'b0;
        for (int c = 8; c < 11; c++) begin
            @(negedge clk);
            chk1($sformatf("drain_rv_c%0d", c), b_rvalid, (c < 10));
            @(posedge clk); #1;
        end

        // Setback after two grants drops both responses.
        b_req = 1'b1; b_we = 1'b0; b_addr = 32'h40;
        @(negedge clk); chk1("sb_gnt0", b_gnt, 1'b1);
        @(posedge clk); #1;
        @(negedge clk); chk1("sb_gnt1", b_gnt, 1'b1);
        @(posedge clk); #1;
        b_setback = 1'b1;
        @(negedge clk); chk1("sb_gnt_forced", b_gnt, 1'b0);
        @(posedge clk); #1;
        b_setback = 1'b0; b_req = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); chk1($sformatf("sb_no_rv%0d", k), b_rvalid, 1'b0);
            @(posedge clk); #1;
        end
        b_req = 1'b1;
        @(negedge clk); chk1("post_sb_gnt", b_gnt, 1'b1);
        @(posedge clk); #1;
        b_req = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            chk1($sformatf("post_sb_rv%0d", k), b_rvalid, (k == 3));
            if (k == 3) chk("post_sb_rdata", b_rdata, 32'h600DCAFE);
            @(posedge clk); #1;
        end

        // Asynchronous reset mid-burst.
        b_req = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        b_req = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk1("pre_rst_rv", b_rvalid, 1'b1);
        chk("pre_rst_rdata", b_rdata, 32'h600DCAFE);
        #1 b_rst = 1'b1; b_req = 1'b1;
        #1;
        chk1("async_rst_gnt", b_gnt, 1'b0);
        chk1("async_rst_rv", b_rvalid, 1'b0);
        chk("async_rst_rdata", b_rdata, 32'h0);
        chk1("async_rst_err", b_err, 1'b0);
        @(posedge clk); #1;
        b_rst = 1'b0; b_req = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); chk1($sformatf("post_rst_rv%0d", k), b_rvalid, 1'b0);
            @(posedge clk); #1;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
